bcd_digit_entry: RTL and testbench

BCD_DIGIT_ENTRY -- requirements
Module: bcd_digit_entry

---
 rtl/bcd_digit_entry_if.sv | 24 ++
 rtl/bcd_digit_entry.sv | 157 +++++++++++++++
 tb/tb_bcd_digit_entry.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_entry_if.sv
// Keypad entry bus: key handshake in, BCD digits and committed-value handshake out.
interface bcd_digit_entry_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] thousands;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [2:0] digit_count;
   logic       out_valid;
   logic       out_ready;
   logic       err;

   modport slave (
      input  key_valid, key_code, out_ready,
      output key_ready, thousands, hundreds, tens, ones, digit_count, out_valid, err
   );

   modport master (
      output key_valid, key_code, out_ready,
      input  key_ready, thousands, hundreds, tens, ones, digit_count, out_valid, err
   );
endinterface

// File: rtl/bcd_digit_entry.sv
// Four-digit BCD keypad entry: digits shift in from the right, backspace shifts out,
// enter commits the value and holds it until the consumer takes it.
module bcd_digit_entry (
   input logic              clk,
   input logic              rst,
   bcd_digit_entry_if.slave bus
);

   localparam int unsigned DW = 4;
   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] MAX_DIGITS = CW'(4);
   localparam logic [DW-1:0] KEY_BKSP   = 4'hA;
   localparam logic [DW-1:0] KEY_CLEAR  = 4'hB;
   localparam logic [DW-1:0] KEY_ENTER  = 4'hC;
   localparam logic [DW-1:0] KEY_DIGMAX = 4'h9;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ENTRY = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] thousands_q, thousands_d;
   logic [DW-1:0] hundreds_q, hundreds_d;
   logic [DW-1:0] tens_q, tens_d;
   logic [DW-1:0] ones_q, ones_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic          key_ready_q, key_ready_d;
   logic          out_valid_q, out_valid_d;

   logic key_accept;
   logic is_digit;

   assign key_accept = bus.key_valid & key_ready_q;
   assign is_digit   = (bus.key_code <= KEY_DIGMAX);

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         thousands_q <= '0;
         hundreds_q  <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         key_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         thousands_q <= thousands_d;
         hundreds_q  <= hundreds_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         count_q     <= count_d;
         err_q       <= err_d;
         key_ready_q <= key_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state logic; ENTRY always holds 1-4 digits, so enter there always commits
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (key_accept && is_digit) state_d = ST_ENTRY;
         end
         ST_ENTRY: begin
            if (key_accept) begin
               if (bus.key_code == KEY_BKSP && count_q == CW'(1)) state_d = ST_EMPTY;
               else if (bus.key_code == KEY_CLEAR)                state_d = ST_EMPTY;
               else if (bus.key_code == KEY_ENTER)                state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      thousands_d = thousands_q;
      hundreds_d  = hundreds_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      count_d     = count_q;
      err_d       = 1'b0;

      if (state_q == ST_HOLD) begin
         if (bus.out_ready) begin
            thousands_d = '0;
            hundreds_d  = '0;
            tens_d      = '0;
            ones_d      = '0;
            count_d     = '0;
         end
      end else if (key_accept) begin
         if (is_digit) begin
            if (count_q < MAX_DIGITS) begin
               thousands_d = hundreds_q;
               hundreds_d  = tens_q;
               tens_d      = ones_q;
               ones_d      = bus.key_code;
               count_d     = count_q + CW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else begin
            unique case (bus.key_code)
               KEY_BKSP: begin
                  if (count_q != '0) begin
                     ones_d      = tens_q;
                     tens_d      = hundreds_q;
                     hundreds_d  = thousands_q;
                     thousands_d = '0;
                     count_d     = count_q - CW'(1);
                  end else begin
                     err_d = 1'b1;
                  end
               end
               KEY_CLEAR: begin
                  thousands_d = '0;
                  hundreds_d  = '0;
                  tens_d      = '0;
                  ones_d      = '0;
                  count_d     = '0;
               end
               KEY_ENTER: begin
                  if (count_q == '0) err_d = 1'b1;
               end
               default: err_d = 1'b1;
            endcase
         end
      end
   end

   // Handshake flags follow the next state so they line up with the digits
   always_comb begin
      key_ready_d = (state_d != ST_HOLD);
      out_valid_d = (state_d == ST_HOLD);
   end

   assign bus.key_ready   = key_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.err         = err_q;
   assign bus.thousands   = thousands_q;
   assign bus.hundreds    = hundreds_q;
   assign bus.tens        = tens_q;
   assign bus.ones        = ones_q;
   assign bus.digit_count = count_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Randomized and directed bench for bcd_digit_entry; an arithmetic model of the entered
// number feeds a scoreboard queue that a negedge monitor drains.
module tb_bcd_digit_entry;

   typedef struct packed {
      logic [3:0] th;
      logic [3:0] hu;
      logic [3:0] te;
      logic [3:0] on;
      logic [2:0] cnt;
      logic       ov;
      logic       kr;
      logic       er;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_cyc  = 0;

   obs_t exp_q[$];

   // Reference model: the entered number as an integer plus digit count
   int m_val  = 0;
   int m_cnt  = 0;
   bit m_hold = 1'b0;
   bit m_err  = 1'b0;

   bcd_digit_entry_if bus ();

   bcd_digit_entry dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) n_cyc <= n_cyc + 1;

   function automatic obs_t model_out();
      obs_t o;
      o.th  = 4'((m_val / 1000) % 10);
      o.hu  = 4'((m_val / 100) % 10);
      o.te  = 4'((m_val / 10) % 10);
      o.on  = 4'(m_val % 10);
      o.cnt = 3'(m_cnt);
      o.ov  = m_hold;
      o.kr  = !m_hold;
      o.er  = m_err;
      return o;
   endfunction

   function automatic obs_t dut_out();
      obs_t o;
      o.th  = bus.thousands;
      o.hu  = bus.hundreds;
      o.te  = bus.tens;
      o.on  = bus.ones;
      o.cnt = bus.digit_count;
      o.ov  = bus.out_valid;
      o.kr  = bus.key_ready;
      o.er  = bus.err;
      return o;
   endfunction

   task automatic compare(input string name, input obs_t act, input obs_t req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got digits %h%h%h%h cnt %0d ov %b kr %b err %b, want digits %h%h%h%h cnt %0d ov %b kr %b err %b",
                  name, act.th, act.hu, act.te, act.on, act.cnt, act.ov, act.kr, act.er,
                  req.th, req.hu, req.te, req.on, req.cnt, req.ov, req.kr, req.er);
      end
   endtask

   function automatic void model_reset();
      m_val  = 0;
      m_cnt  = 0;
      m_hold = 1'b0;
      m_err  = 1'b0;
   endfunction

   function automatic void model_step(input bit kv, input int kc, input bit ordy);
      m_err = 1'b0;
      if (m_hold) begin
         if (ordy) begin
            m_val  = 0;
            m_cnt  = 0;
            m_hold = 1'b0;
         end
      end else if (kv) begin
         if (kc <= 9) begin
            if (m_cnt < 4) begin
               m_val = m_val * 10 + kc;
               m_cnt++;
            end else m_err = 1'b1;
         end else if (kc == 10) begin
            if (m_cnt > 0) begin
               m_val = m_val / 10;
               m_cnt--;
            end else m_err = 1'b1;
         end else if (kc == 11) begin
            m_val = 0;
            m_cnt = 0;
         end else if (kc == 12) begin
            if (m_cnt > 0) m_hold = 1'b1;
            else m_err = 1'b1;
         end else m_err = 1'b1;
      end
   endfunction

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1
   task automatic step(input bit kv, input int kc, input bit ordy);
      bus.key_valid = kv;
      bus.key_code  = 4'(kc);
      bus.out_ready = ordy;
      @(posedge clk);
      model_step(kv, kc, ordy);
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic key(input int kc);
      step(1'b1, kc, 1'b0);
   endtask

   // Asynchronous reset mid-cycle, checked immediately and again by the monitor
   task automatic do_reset();
      @(negedge clk);
      #1;
      bus.key_valid = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      model_reset();
      #1;
      compare("async_reset", dut_out(), model_out());
      @(posedge clk);
      exp_q.push_back(model_out());
      #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare($sformatf("cycle_%0d", n_cyc), dut_out(), e);
         end
      end
   end

   initial begin : watchdog
      #400000;
      n_fail++;
      $display("FAIL watchdog: simulation exceeded time limit, got no finish, want finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : stim
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare("reset_state", dut_out(), model_out());
      rst = 1'b0;

      // Enter 1234, commit, release
      key(1); key(2); key(3); key(4); key(12);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);

      // Enter 42, hold five cycles with keys ignored, then release
      key(4); key(2); key(12);
      step(1'b0, 0, 1'b0);
      step(1'b1, 7, 1'b0);
      step(1'b1, 11, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b0);
      step(1'b0, 0, 1'b1);

      // Overflow on fifth digit, then backspace
      key(9); key(8); key(7); key(6); key(5); key(10);
      key(11);

      // Rejected keys while empty
      key(10); key(12); key(14);
      step(1'b0, 0, 1'b0);

      // Clear, then reset in the middle of entry
      key(5); key(5); key(11);
      key(1); key(0);
      do_reset();
      key(3);

      // Back-to-back digit, backspace, digit
      key(11);
      key(3); key(10); key(7);
      step(1'b0, 0, 1'b0);
      key(11);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         bit kv;
         int kc;
         bit ordy;
         kv   = ($urandom_range(0, 3) != 0);
         kc   = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 9))
                                           : int'($urandom_range(10, 15));
         ordy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 79) == 0) do_reset();
         else step(kv, kc, ordy);
      end

      bus.key_valid = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
